weight_pingpong_buf: RTL and testbench

// Double-buffered (ping-pong) weight store between weight_loader and the conv PE array.

---
 rtl/weight_pingpong_buf_if.sv | 27 ++
 rtl/weight_pingpong_buf.sv | 81 ++++++++
 tb/tb_weight_pingpong_buf.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/weight_pingpong_buf_if.sv
// weight_pingpong_buf_if: write, commit, read and status signals of the ping-pong weight buffer
interface weight_pingpong_buf_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 1152
);
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              fill_done;
    logic              fill_ready;
    logic              bank_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_release;
    logic              ovf_err;
    logic              rd_uninit_err;
    modport master (
        output w_en, w_addr, w_data, fill_done, rd_en, rd_addr, rd_release,
        input  fill_ready, bank_valid, rd_data, rd_valid, ovf_err, rd_uninit_err
    );
    modport slave (
        input  w_en, w_addr, w_data, fill_done, rd_en, rd_addr, rd_release,
        output fill_ready, bank_valid, rd_data, rd_valid, ovf_err, rd_uninit_err
    );
endinterface

// File: rtl/weight_pingpong_buf.sv
// weight_pingpong_buf: double-buffered weight store; WPB_INIT_CHECK_EN adds per-row written maps and rd_uninit_err
module weight_pingpong_buf #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 1152
) (
    input logic                 clk,
    input logic                 rst,
    weight_pingpong_buf_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_err_q, ovf_err_d;
    logic              uninit_err_q, uninit_err_d;
    logic [DATA_W-1:0] mem [2][DEPTH];
    logic              fill_ready, bank_valid, wr_ok, commit, rd_ok, release_ok, rd_row_ok;
    assign fill_ready = !full_q[wr_bank_q];
    assign bank_valid = full_q[rd_bank_q];
    assign wr_ok      = bus.w_en && fill_ready;
    assign commit     = bus.fill_done && fill_ready;
    assign rd_ok      = bus.rd_en && bank_valid;
    assign release_ok = bus.rd_release && bank_valid;
`ifdef WPB_INIT_CHECK_EN
    logic [1:0][DEPTH-1:0] wmap_q, wmap_d;
    always_comb begin
        wmap_d = wmap_q;
        if (release_ok) wmap_d[rd_bank_q] = '0;
        if (wr_ok) wmap_d[wr_bank_q][bus.w_addr] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wmap_q <= '0;
        else     wmap_q <= wmap_d;
    end
    assign rd_row_ok = wmap_q[rd_bank_q][bus.rd_addr];
`else
    assign rd_row_ok = 1'b1;
`endif
    // A write in the commit cycle still lands in the bank being committed.
    always_comb begin
        wr_bank_d = wr_bank_q ^ commit;
        rd_bank_d = rd_bank_q ^ release_ok;
        full_d    = full_q;
        if (commit) full_d[wr_bank_q] = 1'b1;
        if (release_ok) full_d[rd_bank_q] = 1'b0;
        rd_valid_d   = rd_ok;
        rd_data_d    = rd_ok ? (rd_row_ok ? mem[rd_bank_q][bus.rd_addr] : '0) : rd_data_q;
        ovf_err_d    = ovf_err_q | ((bus.w_en | bus.fill_done) & !fill_ready);
        uninit_err_d = uninit_err_q | (rd_ok & !rd_row_ok);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            full_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            ovf_err_q    <= 1'b0;
            uninit_err_q <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            ovf_err_q    <= ovf_err_d;
            uninit_err_q <= uninit_err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_bank_q][bus.w_addr] <= bus.w_data;
    end
    assign bus.fill_ready    = fill_ready;
    assign bus.bank_valid    = bank_valid;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.ovf_err       = ovf_err_q;
    assign bus.rd_uninit_err = uninit_err_q;
endmodule

// File: tb/tb_weight_pingpong_buf.sv
// tb_weight_pingpong_buf: directed ping-pong fill/read/release sequences with a read-data scoreboard
module tb_weight_pingpong_buf;
    localparam int AW = 5;
    localparam int DW = 1152;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];
    weight_pingpong_buf_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    weight_pingpong_buf #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [DW-1:0] pat(input logic [7:0] base, input int a);
        logic [7:0] b;
        b = base + 8'(a * 17);
        return {144{b}};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic status(input string name, input bit fr, input bit bv, input bit ovf);
        chk({name, ".fill_ready"}, 32'(bus.fill_ready), 32'(fr));
        chk({name, ".bank_valid"}, 32'(bus.bank_valid), 32'(bv));
        chk({name, ".ovf_err"}, 32'(bus.ovf_err), 32'(ovf));
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input int a, input logic [DW-1:0] d, input bit done);
        bus.w_en = 1'b1;
        bus.w_addr = AW'(a);
        bus.w_data = d;
        bus.fill_done = done;
        tick();
        bus.w_en = 1'b0;
        bus.fill_done = 1'b0;
    endtask
    task automatic commit();
        bus.fill_done = 1'b1;
        tick();
        bus.fill_done = 1'b0;
    endtask
    task automatic rd(input int a, input bit ok, input logic [DW-1:0] d, input bit rel);
        exp_t e;
        e.data = d;
        e.cyc = cyc + 1;
        if (ok) sb.push_back(e);
        bus.rd_en = 1'b1;
        bus.rd_addr = AW'(a);
        bus.rd_release = rel;
        tick();
        bus.rd_en = 1'b0;
        bus.rd_release = 1'b0;
    endtask
    task automatic rel();
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
    endtask
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 at cycle %0d expected no read", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rd_data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL rd_data: got %0h at cycle %0d expected %0h at cycle %0d",
                             bus.rd_data[31:0], cyc, e.data[31:0], e.cyc);
                end
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [DW-1:0] exp6;
        bit            ue6;
        bus.w_en = 1'b0; bus.w_addr = '0; bus.w_data = '0; bus.fill_done = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_release = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        // 1: reset state, fill rows 0..3, read row 2
        status("reset", 1'b1, 1'b0, 1'b0);
        chk("reset.rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset.rd_data_zero", 32'(bus.rd_data == '0), 32'd1);
        chk("reset.uninit", 32'(bus.rd_uninit_err), 32'd0);
        for (int i = 0; i < 4; i++) wr(i, pat(8'h00, i), 1'b0);
        commit();
        status("t1_commit", 1'b1, 1'b1, 1'b0);
        rd(2, 1'b1, {144{8'h22}}, 1'b0);
        tick();
        rel();
        status("t1_release", 1'b1, 1'b0, 1'b0);
        // 2: fill one bank while reading the other
        for (int i = 0; i < 8; i++) wr(i, pat(8'h40, i), 1'b0);
        commit();
        status("t2_commit1", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.w_en = 1'b1;
            bus.w_addr = AW'(i);
            bus.w_data = pat(8'h80, i);
            rd(i, 1'b1, pat(8'h40, i), 1'b0);
            bus.w_en = 1'b0;
        end
        commit();
        status("t2_both_full", 1'b0, 1'b1, 1'b0);
        rd(3, 1'b1, pat(8'h40, 3), 1'b0);
        rd(6, 1'b1, pat(8'h40, 6), 1'b1);
        status("t2_released", 1'b1, 1'b1, 1'b0);
        rd(5, 1'b1, pat(8'h80, 5), 1'b0);
        // 3: overflow while both banks are full
        for (int i = 0; i < 8; i++) wr(i, pat(8'hC0, i), 1'b0);
        commit();
        status("t3_full", 1'b0, 1'b1, 1'b0);
        wr(0, pat(8'hEE, 0), 1'b1);
        status("t3_ovf", 1'b0, 1'b1, 1'b1);
        rd(0, 1'b1, pat(8'h80, 0), 1'b0);
        rel();
        status("t3_release", 1'b1, 1'b1, 1'b1);
        rd(0, 1'b1, pat(8'hC0, 0), 1'b0);
        // 4: last write coincides with fill_done
        for (int i = 0; i < 7; i++) wr(i, pat(8'h10, i), 1'b0);
        wr(7, pat(8'h10, 7), 1'b1);
        status("t4_commit", 1'b0, 1'b1, 1'b1);
        rel();
        rd(7, 1'b1, pat(8'h10, 7), 1'b0);
        rd(5, 1'b1, pat(8'h10, 5), 1'b0);
        status("t4_read", 1'b1, 1'b1, 1'b1);
        // 5: asynchronous reset during a partial fill
        for (int i = 0; i < 3; i++) wr(i, pat(8'h55, i), 1'b0);
        rd(1, 1'b1, pat(8'h10, 1), 1'b0);
        tick();
        rst = 1'b1;
        #1;
        status("t5_async", 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        status("t5_after", 1'b1, 1'b0, 1'b0);
        chk("t5.uninit", 32'(bus.rd_uninit_err), 32'd0);
        chk("t5.rd_data_zero", 32'(bus.rd_data == '0), 32'd1);
        rd(0, 1'b0, '0, 1'b0);
        chk("t5.rd_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        // 6: read of an unwritten row
`ifdef WPB_INIT_CHECK_EN
        exp6 = '0;
        ue6 = 1'b1;
`else
        exp6 = pat(8'h10, 5);
        ue6 = 1'b0;
`endif
        wr(0, pat(8'h99, 0), 1'b0);
        commit();
        status("t6_commit", 1'b1, 1'b1, 1'b0);
        rd(0, 1'b1, pat(8'h99, 0), 1'b0);
        chk("t6.uninit_row0", 32'(bus.rd_uninit_err), 32'd0);
        rd(5, 1'b1, exp6, 1'b0);
        chk("t6.uninit_row5", 32'(bus.rd_uninit_err), 32'(ue6));
        repeat (4) tick();
        chk("t6.uninit_sticky", 32'(bus.rd_uninit_err), 32'(ue6));
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
